// File: rtl/evt_barrier_injector_if.sv
// Event-stream types and the SNE_EVENT_STREAM handshake interface.
// src = producer side (drives valid/evt), dst = consumer side (drives ready).
package sne_evt_pkg;

  typedef enum logic [1:0] {
    EVT_UPDATE = 2'd0,
    EVT_TIME   = 2'd1,
    EVT_SYNC   = 2'd2,
    EVT_CTRL   = 2'd3
  } evt_op_e;

  typedef struct packed {
    evt_op_e    operation;
    logic [5:0] rsvd;
  } evt_synch_t;

  typedef struct packed {
    evt_synch_t synch;
    logic [7:0] data;
  } evt_t;

endpackage

interface SNE_EVENT_STREAM;
  import sne_evt_pkg::*;

  logic valid;
  logic ready;
  evt_t evt;

  modport src    (output valid, evt, input ready);
  modport dst    (input valid, evt, output ready);
  modport master (output valid, evt, input ready);
  modport slave  (input valid, evt, output ready);
endinterface

// File: rtl/evt_barrier_injector.sv
// Time-barrier injector: forwards an event stream and inserts EVT_TIME
// barriers periodically (period counter) or on a software pulse.
// Optional build macro SNE_BARRIER_INJ_DROP_UPSTREAM_EN: absorb upstream
// EVT_TIME beats so only locally injected barriers reach downstream.
module evt_barrier_injector
  import sne_evt_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic             force_barrier_i,
  input  logic             clr_i,
  SNE_EVENT_STREAM.dst     evt_stream_dst,
  SNE_EVENT_STREAM.src     evt_stream_src,
  output logic             pending_o,
  output logic             overrun_o,
  output logic [CNT_W-1:0] barrier_cnt_o
);

  typedef enum logic {PASS, INJECT} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam evt_t BARRIER_EVT = '{synch: '{operation: EVT_TIME, rsvd: '0}, data: '0};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] bar_cnt_q, bar_cnt_d;

  logic tick;
  logic req;
  logic bar_hs;
  logic pass_ready;
  logic stall;

  // Period counter: free-runs while enabled, wraps at period_i-1 and ticks.
  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q;
    if (!enable_i || period_i == '0) begin
      cnt_d = '0;
    end else if (cnt_q == period_i - ONE) begin
      cnt_d = '0;
      tick  = 1'b1;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  // Stream muxing: passthrough in PASS, constant barrier beat in INJECT.
  always_comb begin
    pass_ready = evt_stream_src.ready;
    evt_stream_src.valid = evt_stream_dst.valid;
    evt_stream_src.evt   = evt_stream_dst.evt;
`ifdef SNE_BARRIER_INJ_DROP_UPSTREAM_EN
    if (evt_stream_dst.evt.synch.operation == EVT_TIME) begin
      pass_ready           = 1'b1;
      evt_stream_src.valid = 1'b0;
    end
`endif
    evt_stream_dst.ready = pass_ready;
    if (state_q == INJECT) begin
      evt_stream_src.valid = 1'b1;
      evt_stream_src.evt   = BARRIER_EVT;
      evt_stream_dst.ready = 1'b0;
    end
  end

  // Request bookkeeping and FSM next state; a stalled passthrough beat
  // (valid but not accepted) blocks the switch to INJECT so it is never dropped.
  always_comb begin
    req    = tick | force_barrier_i;
    bar_hs = (state_q == INJECT) && evt_stream_src.ready;
    stall  = evt_stream_dst.valid && !pass_ready;

    pending_d = bar_hs ? req : (pending_q | req);

    overrun_d = overrun_q;
    if (clr_i)                          overrun_d = 1'b0;
    else if (req && pending_q && !bar_hs) overrun_d = 1'b1;

    bar_cnt_d = bar_cnt_q;
    if (clr_i)       bar_cnt_d = '0;
    else if (bar_hs) bar_cnt_d = bar_cnt_q + ONE;

    state_d = state_q;
    unique case (state_q)
      PASS:    if (pending_q && !stall) state_d = INJECT;
      INJECT:  if (evt_stream_src.ready) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  // All state registers; asynchronous reset drops an in-flight barrier at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= PASS;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      bar_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      bar_cnt_q <= bar_cnt_d;
    end
  end

  assign pending_o     = pending_q;
  assign overrun_o     = overrun_q;
  assign barrier_cnt_o = bar_cnt_q;

endmodule

// File: tb/tb_evt_barrier_injector.sv
// Directed scenarios plus a randomized run against a behavioural model of
// the barrier injector.
module tb_evt_barrier_injector;
  import sne_evt_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable, force_b, clr;
  logic [15:0] period;
  logic        pending, overrun;
  logic [15:0] bcnt;

  SNE_EVENT_STREAM in_if ();
  SNE_EVENT_STREAM out_if ();

  always #5 clk = ~clk;

  evt_barrier_injector #(.CNT_W(16)) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .enable_i        (enable),
    .period_i        (period),
    .force_barrier_i (force_b),
    .clr_i           (clr),
    .evt_stream_dst  (in_if),
    .evt_stream_src  (out_if),
    .pending_o       (pending),
    .overrun_o       (overrun),
    .barrier_cnt_o   (bcnt)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  evt_t BAR, ev, ev_a5, ev_3c;
  int   hs;

  // model state for the randomized run
  int unsigned m_cnt;
  bit          m_owed, m_inj, m_over, m_tick, m_req, m_served, m_next_inj;
  logic [15:0] m_nbar;
  bit          exp_v, exp_r, hold;
  evt_t        exp_e;
  int          r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    enable       = 1'b0;
    period       = '0;
    force_b      = 1'b0;
    clr          = 1'b0;
    in_if.valid  = 1'b0;
    in_if.evt    = '0;
    out_if.ready = 1'b1;
  endtask

  // leaves the bench at the start of cycle 0 after release
  task automatic do_reset();
    cyc();
    rst_n = 1'b0;
    idle();
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    BAR = '0;
    BAR.synch.operation = EVT_TIME;
    ev_a5 = '0; ev_a5.data = 8'hA5;
    ev_3c = '0; ev_3c.data = 8'h3C; ev_3c.synch.operation = EVT_SYNC;
    idle();

    // reset state: src.valid follows dst.valid, status outputs clear
    in_if.valid = 1'b1;
    #3;
    chk("rst.valid_follow1", 32'(out_if.valid), 32'd1);
    chk("rst.pending", 32'(pending), 32'd0);
    chk("rst.overrun", 32'(overrun), 32'd0);
    chk("rst.bcnt", 32'(bcnt), 32'd0);
    in_if.valid = 1'b0;
    #1;
    chk("rst.valid_follow0", 32'(out_if.valid), 32'd0);

    // periodic barriers, period 4
    do_reset();
    period = 16'd4;
    enable = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (c != 0) cyc();
      settle();
      chk($sformatf("per.valid.c%0d", c), 32'(out_if.valid), 32'(c == 5 || c == 9 || c == 13));
      if (c == 5) chk("per.payload", 32'(out_if.evt), 32'(BAR));
    end
    chk("per.bcnt", 32'(bcnt), 32'd3);
    chk("per.overrun", 32'(overrun), 32'd0);

    // single forced barrier, periodic disabled
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 17; c++) begin
      if (c != 0) cyc();
      force_b = (c == 10);
      settle();
      chk($sformatf("frc.valid.c%0d", c), 32'(out_if.valid), 32'(c == 12));
      chk($sformatf("frc.pend.c%0d", c), 32'(pending), 32'(c == 11 || c == 12));
    end
    force_b = 1'b0;
    chk("frc.bcnt", 32'(bcnt), 32'd1);

    // stalled beat holds off the barrier
    do_reset();
    for (int c = 0; c < 9; c++) begin
      if (c != 0) cyc();
      force_b      = (c == 0);
      out_if.ready = (c >= 6);
      in_if.valid  = 1'b1;
      in_if.evt    = (c <= 6) ? ev_a5 : ev_3c;
      settle();
      chk($sformatf("stl.pend.c%0d", c), 32'(pending), 32'(c >= 1 && c <= 7));
      chk($sformatf("stl.valid.c%0d", c), 32'(out_if.valid), 32'd1);
      if (c <= 6) begin
        chk($sformatf("stl.data.c%0d", c), 32'(out_if.evt), 32'(ev_a5));
        chk($sformatf("stl.rdy.c%0d", c), 32'(in_if.ready), 32'(c == 6));
      end else if (c == 7) begin
        chk("stl.bar", 32'(out_if.evt), 32'(BAR));
        chk("stl.rdy.c7", 32'(in_if.ready), 32'd0);
      end else begin
        chk("stl.next", 32'(out_if.evt), 32'(ev_3c));
        chk("stl.rdy.c8", 32'(in_if.ready), 32'd1);
      end
    end
    in_if.valid = 1'b0;

    // coalescing, overrun, clear
    do_reset();
    period = 16'd2;
    hs = 0;
    for (int c = 0; c < 18; c++) begin
      if (c != 0) cyc();
      enable       = (c < 10);
      out_if.ready = (c >= 10 && c <= 12) || (c >= 16);
      clr          = (c == 12) || (c == 15) || (c == 16);
      force_b      = (c == 13);
      settle();
      if (c <= 12) begin
        if (out_if.valid && out_if.ready) hs++;
        chk($sformatf("coa.ovr.c%0d", c), 32'(overrun), 32'(c >= 4));
      end
      if (c == 11) begin
        chk("coa.bcnt1", 32'(bcnt), 32'd1);
        chk("coa.pend0", 32'(pending), 32'd0);
      end
      if (c == 13) chk("clr.bcnt", 32'(bcnt), 32'd0);
      if (c == 13) chk("clr.ovr", 32'(overrun), 32'd0);
      if (c == 16) begin
        chk("clr.pend_kept", 32'(pending), 32'd1);
        chk("clr.inject_kept", 32'(out_if.valid), 32'd1);
        chk("clr.ovr2", 32'(overrun), 32'd0);
      end
      if (c == 17) chk("clr.hs_bcnt", 32'(bcnt), 32'd0);
    end
    chk("coa.one_barrier", 32'(hs), 32'd1);
    clr = 1'b0;
    force_b = 1'b0;

    // upstream EVT_TIME beat
    do_reset();
    ev = '0;
    ev.synch.operation = EVT_TIME;
    ev.data = 8'h11;
    in_if.valid = 1'b1;
    in_if.evt   = ev;
    settle();
`ifdef SNE_BARRIER_INJ_DROP_UPSTREAM_EN
    chk("up.valid", 32'(out_if.valid), 32'd0);
`else
    chk("up.valid", 32'(out_if.valid), 32'd1);
    chk("up.evt", 32'(out_if.evt), 32'(ev));
`endif
    chk("up.ready", 32'(in_if.ready), 32'd1);
    cyc();
    in_if.valid = 1'b0;
    settle();
    chk("up.bcnt", 32'(bcnt), 32'd0);
    chk("up.pend", 32'(pending), 32'd0);

    // reset during INJECT
    do_reset();
    out_if.ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c != 0) cyc();
      force_b = (c == 0);
      settle();
    end
    chk("rmi.injecting", 32'(out_if.valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmi.dropped", 32'(out_if.valid), 32'd0);
    chk("rmi.pend", 32'(pending), 32'd0);
    in_if.valid = 1'b1;
    #1;
    chk("rmi.follow", 32'(out_if.valid), 32'd1);
    in_if.valid = 1'b0;
    cyc();
    rst_n        = 1'b1;
    period       = 16'd3;
    enable       = 1'b1;
    out_if.ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      if (c != 0) cyc();
      settle();
      chk($sformatf("rmi.valid.c%0d", c), 32'(out_if.valid), 32'(c == 4));
    end

    // randomized run against the behavioural model
    do_reset();
    period = 16'($urandom_range(1, 5));
    m_cnt = 0; m_owed = 0; m_inj = 0; m_over = 0; m_nbar = '0; hold = 0;
    for (int c = 0; c < 300; c++) begin
      if (c != 0) cyc();
      enable       = ($urandom_range(0, 7) != 0);
      force_b      = ($urandom_range(0, 9) == 0);
      clr          = ($urandom_range(0, 19) == 0);
      out_if.ready = ($urandom_range(0, 2) != 0);
      if (!hold) begin
        r = int'($urandom_range(0, 2));
        ev = '0;
        ev.synch.operation = evt_op_e'((r == 0) ? 0 : r + 1);
        ev.synch.rsvd = 6'($urandom);
        ev.data = 8'($urandom);
        in_if.valid = 1'($urandom_range(0, 1));
        in_if.evt   = ev;
      end
      settle();

      if (m_inj) begin
        exp_v = 1; exp_e = BAR; exp_r = 0;
      end else begin
        exp_v = in_if.valid; exp_e = in_if.evt; exp_r = out_if.ready;
      end
      chk("rnd.valid", 32'(out_if.valid), 32'(exp_v));
      if (exp_v) chk("rnd.evt", 32'(out_if.evt), 32'(exp_e));
      chk("rnd.ready", 32'(in_if.ready), 32'(exp_r));
      chk("rnd.pend", 32'(pending), 32'(m_owed));
      chk("rnd.ovr", 32'(overrun), 32'(m_over));
      chk("rnd.bcnt", 32'(bcnt), 32'(m_nbar));

      m_tick   = enable && (((m_cnt + 1) % period) == 0);
      m_req    = m_tick || force_b;
      m_served = m_inj && out_if.ready;
      if (clr) m_over = 0;
      else if (m_req && m_owed && !m_served) m_over = 1;
      if (clr) m_nbar = '0;
      else if (m_served) m_nbar = m_nbar + 16'd1;
      m_next_inj = m_inj ? !out_if.ready : (m_owed && !(in_if.valid && !out_if.ready));
      m_owed = m_served ? m_req : (m_owed || m_req);
      m_cnt  = enable ? m_cnt + 1 : 0;
      m_inj  = m_next_inj;
      hold   = in_if.valid && !exp_r;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/evt_barrier_injector.md
# evt_barrier_injector

Time-barrier source for the SNE event fabric. Sits on a single event stream upstream of the multi-channel barrier synchronizer. It forwards ordinary events unchanged and inserts EVT_TIME synch events ("barriers") into the stream, either periodically from a cycle counter or on a software trigger. It never corrupts or reorders a beat in flight and counts emitted barriers for status.

## Interface
- CNT_W, 16: width of the period counter, period register and status counters.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- enable_i  in  1  enables the periodic counter; low holds the counter at 0.
- period_i  in  CNT_W  barrier period in cycles; 0 disables periodic barriers.
- force_barrier_i  in  1  single-cycle pulse requesting one barrier.
- clr_i  in  1  synchronous clear of barrier_cnt_o and overrun_o.
- evt_stream_dst  SNE_EVENT_STREAM.dst  -  incoming stream.
- evt_stream_src  SNE_EVENT_STREAM.src  -  outgoing stream.
- pending_o  out  1  a barrier request is waiting.
- overrun_o  out  1  sticky flag: a request arrived while one was already pending (coalesced).
- barrier_cnt_o  out  CNT_W  number of barriers handshaken on src, wraps at 2^CNT_W.

## Operation
- Period counter cnt_q: it resets to 0 when enable_i=0 or period_i=0. Otherwise it increments each cycle. When cnt_q == period_i-1, it wraps to 0 and raises tick. period_i is compared live, and a change takes effect from the next compare.
- Request = tick | force_barrier_i. On request, pending_q is set at the next edge.
- If pending_q is already 1 and no barrier handshake occurs that cycle, the request is coalesced and overrun_o is set.
- The FSM has two states, PASS and INJECT.
- PASS behaviour:
  - evt_stream_src carries evt_stream_dst combinationally (valid, evt, ready).
  - Transition to INJECT when pending_q=1 and NOT (dst.valid & ~src.ready). A stalled beat is held until it is accepted.
- INJECT behaviour:
  - dst.ready=0.
  - src.valid=1 with evt.synch.operation=EVT_TIME and all other evt fields '0.
  - On src.ready: pending_q is cleared, barrier_cnt_o increments, and the FSM returns to PASS.
  - If a request coincides with the barrier handshake, pending_q stays 1 and overrun_o is not set.
- clr_i zeroes barrier_cnt_o and overrun_o. It does not affect pending_q, cnt_q or the state. If clr_i and a barrier handshake occur in the same cycle, barrier_cnt_o becomes 0.

## Timing
- Reset values: state=PASS, cnt_q=0, pending_q=0, pending_o=0, overrun_o=0, barrier_cnt_o=0. During reset src.valid follows dst.valid combinationally; no barrier is emitted.
- Passthrough latency is 0 cycles (combinational).
- Barrier latency:
  - tick in cycle t gives pending_o=1 in t+1 and a barrier on src.valid in t+2, when the stream is idle or unstalled.
  - force_barrier_i follows the same timing.
- src.valid in INJECT is held stable until src.ready. The payload is constant.
- Reset asserted mid-INJECT drops the barrier immediately (asynchronous). The counter restarts from 0.
- With periodic barriers and no backpressure, the barrier spacing equals period_i cycles.

## Configuration
- SNE_BARRIER_INJ_DROP_UPSTREAM_EN defined:
  - In PASS, incoming beats with evt.synch.operation==EVT_TIME are absorbed: dst.ready=1 and src.valid=0.
  - Only injected barriers appear downstream.
- Undefined: upstream barriers are forwarded like any other event and are not counted in barrier_cnt_o.

## Test plan
- Periodic barriers: period_i=4, enable_i from cycle 0, dst idle, src.ready=1 → barriers in cycles 5, 9, 13. barrier_cnt_o=3 in cycle 14. overrun_o=0.
- Force pulse with idle stream: force_barrier_i pulsed in cycle 10, period_i=0 → pending_o=1 in cycle 11 and a single barrier in cycle 12. No further barriers.
- Stalled beat during a request:
  - Stimulus: dst.valid=1 with data 0xA5 and src.ready=0 over cycles 0-5; force_barrier_i in cycle 0; src.ready=1 from cycle 6.
  - Required: 0xA5 held stable and accepted in cycle 6, then the barrier in cycle 7. dst.ready=0 in cycle 7.
- Coalescing and overrun: period_i=2, src.ready=0 for 10 cycles → exactly one barrier after ready rises, overrun_o=1. After a clr_i pulse: overrun_o=0, barrier_cnt_o=0, pending_q unaffected.
- Upstream barrier: dst sends EVT_TIME with src.ready=1 → forwarded when the macro is undefined; dst.ready=1 and src.valid=0 when the macro is defined.
- Reset mid-INJECT: rst_ni low while src.valid=1 in INJECT → barrier dropped immediately, all outputs at reset values. After release with period_i=3, the first barrier appears in cycle 4 relative to release.
